// File: rtl/dram_write_coalescer_pkg.sv
// Shared configuration defaults plus the coalescer's derived widths and FSM state type.
package TauCfg;
    localparam int unsigned VSIZE          = 4;
    localparam int unsigned CACHE_SIZE     = 4;
    localparam int unsigned GLOBAL_ADDR_BW = 32;
    localparam int unsigned DATA_BW        = 32;
endpackage

package dram_write_coalescer_pkg;
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } state_t;

    function automatic int unsigned cl_bw(input int unsigned csize);
        return $clog2(csize);
    endfunction

    // A zero-width counter is illegal, so a disabled timeout still gets one bit.
    function automatic int unsigned to_bw(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction
endpackage

// File: rtl/dram_write_coalescer_if.sv
// Warp input, write-data and DRAM write-port bundle for the write coalescer.
interface dram_write_coalescer_if #(
    parameter int unsigned VSIZE = TauCfg::VSIZE,
    parameter int unsigned CSIZE = TauCfg::CACHE_SIZE,
    parameter int unsigned GBW   = TauCfg::GLOBAL_ADDR_BW,
    parameter int unsigned DBW   = TauCfg::DATA_BW
);
    logic                        addrval_rdy;
    logic                        addrval_ack;
    logic [VSIZE-1:0][GBW-1:0]   i_address;
    logic [VSIZE-1:0]            i_valid;
    logic                        alu_dat_rdy;
    logic                        alu_dat_ack;
    logic [VSIZE-1:0][DBW-1:0]   i_alu_dat;
    logic                        i_flush;
    logic                        dramw_rdy;
    logic                        dramw_ack;
    logic [GBW-1:0]              o_dramwa;
    logic [CSIZE-1:0][DBW-1:0]   o_dramwd;
    logic [CSIZE-1:0]            o_dramw_mask;

    modport slave (
        input  addrval_rdy, i_address, i_valid, alu_dat_rdy, i_alu_dat, i_flush, dramw_ack,
        output addrval_ack, alu_dat_ack, dramw_rdy, o_dramwa, o_dramwd, o_dramw_mask
    );

    modport master (
        output addrval_rdy, i_address, i_valid, alu_dat_rdy, i_alu_dat, i_flush, dramw_ack,
        input  addrval_ack, alu_dat_ack, dramw_rdy, o_dramwa, o_dramwd, o_dramw_mask
    );
endinterface

// File: rtl/dram_write_coalescer_lane_group_select.sv
// Picks the lowest remaining lane's line, marks all remaining lanes on it and
// scatters their data to word offsets (higher lane wins on a shared offset).
module lane_group_select
    import dram_write_coalescer_pkg::*;
#(
    parameter int unsigned VSIZE = TauCfg::VSIZE,
    parameter int unsigned CSIZE = TauCfg::CACHE_SIZE,
    parameter int unsigned GBW   = TauCfg::GLOBAL_ADDR_BW,
    parameter int unsigned DBW   = TauCfg::DATA_BW
) (
    input  logic [VSIZE-1:0]                  i_rem,
    input  logic [VSIZE-1:0][GBW-1:0]         i_addr,
    input  logic [VSIZE-1:0][DBW-1:0]         i_data,
    output logic                              o_any,
    output logic [GBW-cl_bw(CSIZE)-1:0]       o_line,
    output logic [VSIZE-1:0]                  o_lanes,
    output logic [CSIZE-1:0][DBW-1:0]         o_words,
    output logic [CSIZE-1:0]                  o_wmask
);
    localparam int unsigned CL_BW = cl_bw(CSIZE);

    logic w_found;

    always_comb begin
        o_any   = |i_rem;
        o_line  = '0;
        o_lanes = '0;
        o_words = '0;
        o_wmask = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < VSIZE; i++) begin
            if (i_rem[i] && !w_found) begin
                o_line  = i_addr[i][GBW-1:CL_BW];
                w_found = 1'b1;
            end
        end
        for (int unsigned i = 0; i < VSIZE; i++) begin
            o_lanes[i] = i_rem[i] && (i_addr[i][GBW-1:CL_BW] == o_line);
        end
        // Ascending order lets the higher lane overwrite a shared offset.
        for (int unsigned i = 0; i < VSIZE; i++) begin
            if (o_lanes[i]) begin
                o_words[i_addr[i][CL_BW-1:0]] = i_data[i];
                o_wmask[i_addr[i][CL_BW-1:0]] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/dram_write_coalescer.sv
// Coalesces per-lane warp writes into line-sized DRAM writes through one
// combine register, emitting on line change, full mask, idle timeout or flush.
module dram_write_coalescer
    import dram_write_coalescer_pkg::*;
#(
    parameter int unsigned VSIZE   = TauCfg::VSIZE,
    parameter int unsigned CSIZE   = TauCfg::CACHE_SIZE,
    parameter int unsigned GBW     = TauCfg::GLOBAL_ADDR_BW,
    parameter int unsigned DBW     = TauCfg::DATA_BW,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    dram_write_coalescer_if.slave     io_bus
);
    localparam int unsigned CL_BW = cl_bw(CSIZE);
    localparam int unsigned LN_BW = GBW - CL_BW;
    localparam int unsigned TO_BW = to_bw(TIMEOUT);
    localparam logic [TO_BW-1:0] TO_MAX = TO_BW'(TIMEOUT);

    state_t                    r_state, w_state_next;
    logic [VSIZE-1:0]          r_rem;
    logic [VSIZE-1:0][GBW-1:0] r_addr;
    logic [VSIZE-1:0][DBW-1:0] r_data;
    logic                      r_cr_valid;
    logic [LN_BW-1:0]          r_cr_line;
    logic [CSIZE-1:0][DBW-1:0] r_cr_data;
    logic [CSIZE-1:0]          r_cr_mask;
    logic [TO_BW-1:0]          r_idle_cnt;
    logic                      r_flush_pend;
    logic                      r_emit_hold;

    logic                      w_any;
    logic [LN_BW-1:0]          w_line;
    logic [VSIZE-1:0]          w_lanes;
    logic [CSIZE-1:0][DBW-1:0] w_words;
    logic [CSIZE-1:0]          w_wmask;
    logic                      w_accept;
    logic                      w_timeout;
    logic                      w_conflict;
    logic                      w_rdy;
    logic                      w_emit;
    logic                      w_take;
    logic                      w_merge;
    logic [VSIZE-1:0]          w_rem_left;

    lane_group_select #(
        .VSIZE(VSIZE),
        .CSIZE(CSIZE),
        .GBW  (GBW),
        .DBW  (DBW)
    ) u_sel (
        .i_rem  (r_rem),
        .i_addr (r_addr),
        .i_data (r_data),
        .o_any  (w_any),
        .o_line (w_line),
        .o_lanes(w_lanes),
        .o_words(w_words),
        .o_wmask(w_wmask)
    );

    // Emit request is built from registers only; r_emit_hold keeps it up until ack.
    always_comb begin
        w_accept   = i_rst_n && io_bus.addrval_rdy && io_bus.alu_dat_rdy && (r_state == ST_IDLE);
        w_timeout  = (TIMEOUT != 0) && (r_idle_cnt == TO_MAX);
        w_conflict = (r_state == ST_SPLIT) && w_any && (w_line != r_cr_line);
        w_rdy      = r_cr_valid && (r_emit_hold || (&r_cr_mask) || w_conflict || w_timeout ||
                                    ((r_state == ST_IDLE) && r_flush_pend));
        w_emit     = w_rdy && io_bus.dramw_ack;
        w_take     = (r_state == ST_SPLIT) && (!w_rdy || w_emit);
        w_merge    = w_take && r_cr_valid && !w_emit;
        w_rem_left = r_rem & ~w_lanes;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept && (|io_bus.i_valid)) w_state_next = ST_SPLIT;
            ST_SPLIT: if (w_take && (w_rem_left == '0)) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_rem        <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_cr_valid   <= 1'b0;
            r_cr_line    <= '0;
            r_cr_data    <= '0;
            r_cr_mask    <= '0;
            r_idle_cnt   <= '0;
            r_flush_pend <= 1'b0;
            r_emit_hold  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_emit_hold <= w_rdy && !w_emit;

            if (w_accept) begin
                r_rem  <= io_bus.i_valid;
                r_addr <= io_bus.i_address;
                r_data <= io_bus.i_alu_dat;
            end else if (w_take) begin
                r_rem <= w_rem_left;
            end

            if (w_take) begin
                r_cr_valid <= 1'b1;
                r_cr_line  <= w_line;
                r_cr_mask  <= w_merge ? (r_cr_mask | w_wmask) : w_wmask;
                for (int unsigned i = 0; i < CSIZE; i++) begin
                    if (!w_merge || w_wmask[i]) r_cr_data[i] <= w_words[i];
                end
            end else if (w_emit) begin
                r_cr_valid <= 1'b0;
                r_cr_mask  <= '0;
            end

            if (w_take || w_emit) begin
                r_idle_cnt <= '0;
            end else if ((r_state == ST_IDLE) && r_cr_valid && !w_accept && (r_idle_cnt != TO_MAX)) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end

            r_flush_pend <= io_bus.i_flush ||
                            (r_flush_pend && !(w_emit || ((r_state == ST_IDLE) && !r_cr_valid)));
        end
    end

    assign io_bus.addrval_ack  = w_accept;
    assign io_bus.alu_dat_ack  = w_accept;
    assign io_bus.dramw_rdy    = w_rdy;
    assign io_bus.o_dramwa     = {r_cr_line, {CL_BW{1'b0}}};
    assign io_bus.o_dramwd     = r_cr_data;
    assign io_bus.o_dramw_mask = r_cr_mask;
endmodule

// File: tb/tb_dram_write_coalescer.sv
// Directed checks of the write coalescer: grouping, merging, timeout, flush, stall and reset.
module tb_dram_write_coalescer;
    localparam int unsigned VS = 4;
    localparam int unsigned CS = 4;
    localparam int unsigned GB = 8;
    localparam int unsigned DB = 8;
    localparam int unsigned TO = 16;

    typedef struct {
        logic [7:0]  wa;
        logic [3:0]  mask;
        logic [31:0] wd;
        int          cyc;
    } emit_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    cyc = 0;
    int    n_assert = 0;
    int    n_fail = 0;
    emit_t q[$];

    always #5 clk = ~clk;

    dram_write_coalescer_if #(.VSIZE(VS), .CSIZE(CS), .GBW(GB), .DBW(DB)) bus ();

    dram_write_coalescer #(
        .VSIZE  (VS),
        .CSIZE  (CS),
        .GBW    (GB),
        .DBW    (DB),
        .TIMEOUT(TO)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .io_bus (bus)
    );

    // Records each DRAM write just before the edge that transfers it.
    always @(negedge clk) begin
        emit_t e;
        cyc++;
        #4;
        if (rst_n && bus.dramw_rdy && bus.dramw_ack) begin
            e.wa   = bus.o_dramwa;
            e.mask = bus.o_dramw_mask;
            e.wd   = bus.o_dramwd;
            e.cyc  = cyc;
            q.push_back(e);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send_warp(input logic [31:0] addr, input logic [3:0] valid, input logic [31:0] data);
        logic got;
        got = 1'b0;
        bus.i_address   = addr;
        bus.i_valid     = valid;
        bus.i_alu_dat   = data;
        bus.addrval_rdy = 1'b1;
        bus.alu_dat_rdy = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            #1;
            if (bus.addrval_ack && bus.alu_dat_ack) got = 1'b1;
            step();
        end
        bus.addrval_rdy = 1'b0;
        bus.alu_dat_rdy = 1'b0;
        chk("warp_accept", 64'(got), 64'd1);
    endtask

    task automatic wait_emits(input int n, input int budget, input string tag);
        for (int k = 0; k < budget && q.size() < n; k++) step();
        chk(tag, 64'(q.size()), 64'(n));
    endtask

    task automatic pulse_flush();
        bus.i_flush = 1'b1;
        step();
        bus.i_flush = 1'b0;
    endtask

    initial begin
        logic got;
        bus.addrval_rdy = 1'b0;
        bus.alu_dat_rdy = 1'b0;
        bus.i_address   = '0;
        bus.i_valid     = '0;
        bus.i_alu_dat   = '0;
        bus.i_flush     = 1'b0;
        bus.dramw_ack   = 1'b0;
        step();
        step();
        chk("rst_rdy",  64'(bus.dramw_rdy), 64'd0);
        chk("rst_wa",   64'(bus.o_dramwa), 64'd0);
        chk("rst_wd",   64'(bus.o_dramwd), 64'd0);
        chk("rst_mask", 64'(bus.o_dramw_mask), 64'd0);
        rst_n = 1'b1;
        step();

        // Full line in one group: emitted right away.
        bus.dramw_ack = 1'b1;
        send_warp({8'd3, 8'd2, 8'd1, 8'd0}, 4'b1111, {8'h44, 8'h33, 8'h22, 8'h11});
        wait_emits(1, 5, "full_count");
        chk("full_wa",   64'(q[0].wa), 64'h00);
        chk("full_mask", 64'(q[0].mask), 64'hF);
        chk("full_wd",   64'(q[0].wd), 64'h44332211);
        repeat (3) step();
        chk("full_single", 64'(q.size()), 64'd1);

        // Two lines interleaved across lanes; second line leaves on timeout.
        q.delete();
        send_warp({8'd9, 8'd1, 8'd8, 8'd0}, 4'b1111, {8'hD3, 8'hC2, 8'hB1, 8'hA0});
        wait_emits(2, 40, "split_count");
        chk("split0_wa",   64'(q[0].wa), 64'h00);
        chk("split0_mask", 64'(q[0].mask), 64'h3);
        chk("split0_wd",   64'(q[0].wd), 64'h0000C2A0);
        chk("split1_wa",   64'(q[1].wa), 64'h08);
        chk("split1_mask", 64'(q[1].mask), 64'h3);
        chk("split1_wd",   64'(q[1].wd), 64'h0000D3B1);
        chk("timeout_gap", 64'(q[1].cyc - q[0].cyc), 64'd17);

        // Two warps on the same line merge; flush releases them.
        q.delete();
        send_warp({8'd0, 8'd0, 8'd0, 8'd4}, 4'b0001, {8'h00, 8'h00, 8'h00, 8'h5A});
        send_warp({8'd0, 8'd0, 8'd0, 8'd6}, 4'b0001, {8'h00, 8'h00, 8'h00, 8'h6B});
        repeat (2) step();
        chk("merge_held", 64'(q.size()), 64'd0);
        pulse_flush();
        wait_emits(1, 10, "merge_count");
        chk("merge_wa",   64'(q[0].wa), 64'h04);
        chk("merge_mask", 64'(q[0].mask), 64'h5);
        chk("merge_wd",   64'(q[0].wd), 64'h006B005A);

        // Two lanes on one word: higher lane wins.
        q.delete();
        send_warp({8'd0, 8'd5, 8'd0, 8'd5}, 4'b0101, {8'h00, 8'h0B, 8'h00, 8'h0A});
        step();
        pulse_flush();
        wait_emits(1, 10, "dup_count");
        chk("dup_wa",   64'(q[0].wa), 64'h04);
        chk("dup_mask", 64'(q[0].mask), 64'h2);
        chk("dup_wd",   64'(q[0].wd), 64'h00000B00);

        // DRAM back-pressure during a line change stalls SPLIT and the warp port.
        q.delete();
        bus.dramw_ack = 1'b0;
        send_warp({8'd0, 8'd0, 8'h14, 8'h10}, 4'b0011, {8'h00, 8'h00, 8'h22, 8'h11});
        step();
        bus.i_valid     = 4'b0000;
        bus.addrval_rdy = 1'b1;
        bus.alu_dat_rdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("stall_rdy",  64'(bus.dramw_rdy), 64'd1);
            chk("stall_ack",  64'(bus.addrval_ack), 64'd0);
            chk("stall_wa",   64'(bus.o_dramwa), 64'h10);
            chk("stall_mask", 64'(bus.o_dramw_mask), 64'h1);
            chk("stall_wd",   64'(bus.o_dramwd), 64'h00000011);
            step();
        end
        bus.dramw_ack = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            #1;
            if (bus.addrval_ack) got = 1'b1;
            step();
        end
        bus.addrval_rdy = 1'b0;
        bus.alu_dat_rdy = 1'b0;
        chk("stall_release", 64'(got), 64'd1);
        pulse_flush();
        wait_emits(2, 10, "stall_count");
        chk("stall0_wa",   64'(q[0].wa), 64'h10);
        chk("stall0_mask", 64'(q[0].mask), 64'h1);
        chk("stall1_wa",   64'(q[1].wa), 64'h14);
        chk("stall1_mask", 64'(q[1].mask), 64'h1);
        chk("stall1_wd",   64'(q[1].wd), 64'h00000022);

        // Reset while a line is being presented discards it.
        q.delete();
        bus.dramw_ack = 1'b0;
        send_warp({8'h23, 8'h22, 8'h21, 8'h20}, 4'b1111, {8'h04, 8'h03, 8'h02, 8'h01});
        step();
        chk("pre_rst_rdy", 64'(bus.dramw_rdy), 64'd1);
        bus.addrval_rdy = 1'b1;
        bus.alu_dat_rdy = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rdy",  64'(bus.dramw_rdy), 64'd0);
        chk("mid_rst_wa",   64'(bus.o_dramwa), 64'd0);
        chk("mid_rst_wd",   64'(bus.o_dramwd), 64'd0);
        chk("mid_rst_mask", 64'(bus.o_dramw_mask), 64'd0);
        chk("mid_rst_ack",  64'({bus.addrval_ack, bus.alu_dat_ack}), 64'd0);
        bus.addrval_rdy = 1'b0;
        bus.alu_dat_rdy = 1'b0;
        step();
        rst_n = 1'b1;
        bus.dramw_ack = 1'b1;
        repeat (20) step();
        chk("post_rst_no_emit", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
